// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA pixel fetch path.
package vga_pkg;
  localparam int HD       = 640;
  localparam int VD       = 480;
  localparam int FB_W_DEF = 320;
  localparam int FB_H_DEF = 240;
  localparam int FB_SIZE  = 76800;

  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int ADDR_W  = 18;
  localparam int IDX_W   = 4;
  localparam int COLOR_W = 12;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    SWAP_IDLE  = 2'd0,
    SWAP_ARMED = 2'd1,
    SWAP_DONE  = 2'd2
  } swap_state_t;

  // Row offset for a 320-wide framebuffer: row*320 = (row<<8) + (row<<6).
  function automatic logic [ADDR_W-1:0] row_base320(input logic [7:0] row);
    logic [ADDR_W-1:0] r18;
    r18 = {10'd0, row};
    return (r18 << 8) + (r18 << 6);
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// Resettable shift register used to align sync, enable and coordinates with
// the framebuffer/palette pipeline.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] taps [DEPTH];

  // Shift the input through DEPTH registers; reset clears every tap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];
endmodule

// File: rtl/vga_pixel_fetch.sv
// VGA pixel fetch: framebuffer address generation, palette lookup, sync
// alignment and vsync-synchronised display-buffer swap.
// Optional feature: define VGA_CURSOR_EN to add a 16x16 cursor overlay.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int          MEM_LAT   = 2,
  parameter int          FB_W      = FB_W_DEF,
  parameter int          FB_H      = FB_H_DEF,
  parameter logic [11:0] CUR_COLOR = 12'hFFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [X_W-1:0]     pixel_x,
  input  logic [Y_W-1:0]     pixel_y,
  input  logic               video_enable,
  input  logic               hsync,
  input  logic               vsync,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [IDX_W-1:0]   mem_rdata,
  input  logic               pal_we,
  input  logic [IDX_W-1:0]   pal_addr,
  input  logic [COLOR_W-1:0] pal_wdata,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic               disp_buf,
`ifdef VGA_CURSOR_EN
  input  logic [X_W-1:0]     cursor_x,
  input  logic [Y_W-1:0]     cursor_y,
`endif
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               vga_hsync,
  output logic               vga_vsync
);
  // Sync/enable path: MEM_LAT+1 taps here plus the output register give the
  // same MEM_LAT+2 depth as address register + memory + colour register.
  localparam int ALIGN = MEM_LAT + 1;

  logic [ADDR_W-1:0]  addr_next;
  logic [ADDR_W-1:0]  row_off;
  logic [ADDR_W-1:0]  base;
  logic [7:0]         row;
  logic [8:0]         col;
  logic [2:0]         sync_d;
  logic               en_d;
  logic               hs_d;
  logic               vs_d;
  logic [COLOR_W-1:0] palette [16];
  rgb444_t            rgb_q;
  swap_state_t        state;
  logic               vsync_prev;
  logic               vs_rise;
  logic               unused_lsbs;

  // Coordinates are 2x scaled, so their LSBs never reach the address.
  assign unused_lsbs = pixel_x[0] ^ pixel_y[0];

  // Framebuffer word address of the current pixel in the displayed buffer.
  always_comb begin
    row = pixel_y[8:1];
    col = pixel_x[9:1];
    if (FB_W == 320) begin
      row_off = row_base320(row);
    end else begin
      row_off = ADDR_W'(row) * ADDR_W'(FB_W);
    end
    if (disp_buf) begin
      base = ADDR_W'(FB_W * FB_H);
    end else begin
      base = 18'd0;
    end
    addr_next = base + row_off + {9'd0, col};
  end

  // Stage A: register the address while visible, hold it during blanking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr <= 18'd0;
    end else if (video_enable) begin
      mem_addr <= addr_next;
    end else begin
      mem_addr <= mem_addr;
    end
  end

  vga_delay_line #(.WIDTH(3), .DEPTH(ALIGN)) u_sync_dly (
    .clock (clock),
    .reset (reset),
    .d     ({video_enable, hsync, vsync}),
    .q     (sync_d)
  );

  assign en_d = sync_d[2];
  assign hs_d = sync_d[1];
  assign vs_d = sync_d[0];

`ifdef VGA_CURSOR_EN
  logic [X_W+Y_W-1:0] coord_d;
  logic [X_W-1:0]     px_d;
  logic [Y_W-1:0]     py_d;
  logic               cur_hit;

  vga_delay_line #(.WIDTH(X_W+Y_W), .DEPTH(ALIGN)) u_coord_dly (
    .clock (clock),
    .reset (reset),
    .d     ({pixel_x, pixel_y}),
    .q     (coord_d)
  );

  assign px_d = coord_d[X_W+Y_W-1:Y_W];
  assign py_d = coord_d[Y_W-1:0];

  // Cursor box test on the aligned coordinates; widened to avoid wrap.
  always_comb begin
    if (({1'b0, px_d} >= {1'b0, cursor_x}) &&
        ({1'b0, px_d} <  ({1'b0, cursor_x} + 11'd16)) &&
        ({1'b0, py_d} >= {1'b0, cursor_y}) &&
        ({1'b0, py_d} <  ({1'b0, cursor_y} + 10'd16))) begin
      cur_hit = 1'b1;
    end else begin
      cur_hit = 1'b0;
    end
  end
`endif

  // Palette RAM: synchronous write, not cleared by reset.
  always_ff @(posedge clock) begin
    if (pal_we) palette[pal_addr] <= pal_wdata;
  end

  // Stage C: palette lookup onto the colour pins, blanked outside video.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb_q     <= 12'h000;
      vga_hsync <= 1'b0;
      vga_vsync <= 1'b0;
    end else begin
      vga_hsync <= hs_d;
      vga_vsync <= vs_d;
      if (!en_d) begin
        rgb_q <= 12'h000;
`ifdef VGA_CURSOR_EN
      end else if (cur_hit) begin
        rgb_q <= rgb444_t'(CUR_COLOR);
`endif
      end else begin
        rgb_q <= rgb444_t'(palette[mem_rdata]);
      end
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

  assign vs_rise = vsync & ~vsync_prev;

  // Swap FSM: arm on request, flip the displayed buffer on a raw vsync rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= SWAP_IDLE;
      swap_ack   <= 1'b0;
      disp_buf   <= 1'b0;
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= vsync;
      case (state)
        SWAP_IDLE: begin
          swap_ack <= 1'b0;
          if (swap_req) state <= SWAP_ARMED;
        end
        SWAP_ARMED: begin
          swap_ack <= 1'b0;
          if (!swap_req) begin
            state <= SWAP_IDLE;
          end else if (vs_rise) begin
            state    <= SWAP_DONE;
            swap_ack <= 1'b1;
            disp_buf <= ~disp_buf;
          end
        end
        SWAP_DONE: begin
          swap_ack <= 1'b0;
          state    <= SWAP_IDLE;
        end
        default: begin
          swap_ack <= 1'b0;
          state    <= SWAP_IDLE;
        end
      endcase
    end
  end
endmodule
